// File: rtl/seg_scan_driver.sv
// N-digit multiplexed seven-segment scan driver with active-low anodes/cathodes.
// Adds a refresh prescaler, frame-coherent input snapshot, leading-zero blanking, PWM dimming and a ghosting guard.
module seg_scan_driver #(
   parameter int DIGITS      = 4,
   parameter int REFRESH_DIV = 100000,
   parameter int BRIGHT_W    = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [4*DIGITS-1:0]   bcd_in,
   input  logic [DIGITS-1:0]     dp_in,
   input  logic                  blank_lz,
   input  logic [BRIGHT_W-1:0]   brightness,
   output logic [DIGITS-1:0]     sseg_a_o,
   output logic [6:0]            sseg_c_o,
   output logic                  sseg_dp_o,
   output logic                  frame_start_o
);

   localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

   logic [CNT_W-1:0]    cnt;
   logic [IDX_W-1:0]    idx;
   logic [BRIGHT_W-1:0] pwm;
   logic                rst_q;

   logic [4*DIGITS-1:0] bcd_sh;
   logic [DIGITS-1:0]   dp_sh;
   logic                blank_sh;
   logic [BRIGHT_W-1:0] bright_sh;

   logic                tick;
   logic                load;
   logic [DIGITS-1:0]   blank_vec;
   logic                lead;
   logic [3:0]          cur_nib;
   logic                cur_blank;
   logic                cur_dp;
   logic                anode_en;
   logic [6:0]          cur_seg;

   function automatic logic [6:0] seg_decode(input logic [3:0] v);
      logic [6:0] s;
      case (v)
         4'd0:    s = 7'b1000000;
         4'd1:    s = 7'b1111001;
         4'd2:    s = 7'b0100100;
         4'd3:    s = 7'b0110000;
         4'd4:    s = 7'b0011001;
         4'd5:    s = 7'b0010010;
         4'd6:    s = 7'b0000010;
         4'd7:    s = 7'b1111000;
         4'd8:    s = 7'b0000000;
         4'd9:    s = 7'b0010000;
         default: s = 7'b0111111;
      endcase
      return s;
   endfunction

   assign tick = (cnt == CNT_LAST);
   // rst_q marks the first cycle out of reset so the shadow picks up live inputs immediately.
   assign load = rst_q || (tick && (idx == IDX_LAST));

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt       <= '0;
         idx       <= '0;
         pwm       <= '0;
         rst_q     <= 1'b1;
         bcd_sh    <= '0;
         dp_sh     <= '0;
         blank_sh  <= 1'b0;
         bright_sh <= '0;
      end else begin
         rst_q <= 1'b0;
         pwm   <= pwm + 1'b1;
         if (tick) begin
            cnt <= '0;
            idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
         end else begin
            cnt <= cnt + 1'b1;
         end
         if (load) begin
            bcd_sh    <= bcd_in;
            dp_sh     <= dp_in;
            blank_sh  <= blank_lz;
            bright_sh <= brightness;
         end
      end
   end

   // Walk from the most significant digit down; blanking stops at the first non-zero nibble.
   always_comb begin
      blank_vec = '0;
      lead      = blank_sh;
      for (int i = DIGITS - 1; i >= 1; i--) begin
         if (bcd_sh[4*i +: 4] != 4'd0) lead = 1'b0;
         blank_vec[i] = lead;
      end
   end

   always_comb begin
      cur_nib   = bcd_sh[4*int'(idx) +: 4];
      cur_blank = blank_vec[idx];
      cur_dp    = dp_sh[idx];
      cur_seg   = seg_decode(cur_nib);
      anode_en  = (cnt != '0) && (pwm <= bright_sh) && !cur_blank;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sseg_a_o      <= '1;
         sseg_c_o      <= 7'h7F;
         sseg_dp_o     <= 1'b1;
         frame_start_o <= 1'b0;
      end else begin
         frame_start_o <= load;
         sseg_a_o      <= anode_en ? ~(DIGITS'(1) << idx) : '1;
         sseg_c_o      <= cur_blank ? 7'h7F : cur_seg;
         sseg_dp_o     <= cur_blank ? 1'b1 : ~cur_dp;
      end
   end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver: cycle-by-cycle comparison against an arithmetic model of the scan,
// plus directed literal checks of decoded patterns, blanking, snapshot timing, dimming and reset.
module tb_seg_scan_driver;

   localparam int D  = 4;
   localparam int R  = 4;
   localparam int BW = 2;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [15:0]   bcd_in = '0;
   logic [3:0]    dp_in = '0;
   logic          blank_lz = 1'b0;
   logic [BW-1:0] brightness = '1;
   logic [3:0]    sseg_a_o;
   logic [6:0]    sseg_c_o;
   logic          sseg_dp_o;
   logic          frame_start_o;

   int checks   = 0;
   int failures = 0;
   int pos      = 0;

   seg_scan_driver #(.DIGITS(D), .REFRESH_DIV(R), .BRIGHT_W(BW)) dut (
      .clk           (clk),
      .rst           (rst),
      .bcd_in        (bcd_in),
      .dp_in         (dp_in),
      .blank_lz      (blank_lz),
      .brightness    (brightness),
      .sseg_a_o      (sseg_a_o),
      .sseg_c_o      (sseg_c_o),
      .sseg_dp_o     (sseg_dp_o),
      .frame_start_o (frame_start_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: state before edge k (k=1 is the first edge after reset) is pure arithmetic on k.
   logic [6:0]    seg_tab [16];
   bit            model_on = 1'b0;
   int            k = 0;
   logic [15:0]   m_bcd;
   logic [3:0]    m_dp;
   logic          m_blz;
   logic [BW-1:0] m_bri;
   logic [3:0]    exp_a;
   logic [6:0]    exp_c;
   logic          exp_dp;
   logic          exp_fs;

   initial begin
      seg_tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                  7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                  7'b0000000, 7'b0010000, 7'b0111111, 7'b0111111,
                  7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111};
      forever begin
         @(posedge clk);
         if (rst) begin
            model_on = 1'b1;
            k = 0;
            m_bcd = '0; m_dp = '0; m_blz = 1'b0; m_bri = '0;
            exp_a = 4'hF; exp_c = 7'h7F; exp_dp = 1'b1; exp_fs = 1'b0;
         end else if (model_on) begin
            int c0, dig, pw, nib;
            bit blanked;
            k++;
            c0  = (k - 1) % R;
            dig = ((k - 1) / R) % D;
            pw  = (k - 1) % (1 << BW);
            nib = int'((m_bcd >> (4 * dig)) & 16'hF);
            blanked = m_blz && (dig != 0) && ((m_bcd >> (4 * dig)) == 16'h0);
            exp_a = 4'hF;
            if (!blanked && c0 != 0 && pw <= int'(m_bri)) exp_a[dig] = 1'b0;
            exp_c  = blanked ? 7'h7F : seg_tab[nib];
            exp_dp = blanked ? 1'b1 : ~m_dp[dig];
            exp_fs = (k == 1) || (((k - 1) % (R * D)) == R * D - 1);
            if (exp_fs) begin
               m_bcd = bcd_in; m_dp = dp_in; m_blz = blank_lz; m_bri = brightness;
            end
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (model_on) begin
            chk("model_anode", 32'(sseg_a_o), 32'(exp_a));
            chk("model_cathode", 32'(sseg_c_o), 32'(exp_c));
            chk("model_dp", 32'(sseg_dp_o), 32'(exp_dp));
            chk("model_frame_start", 32'(frame_start_o), 32'(exp_fs));
         end
      end
   end

   task automatic wait_frame();
      int t = 0;
      bit found = 1'b0;
      while (!found && t < 40) begin
         @(negedge clk);
         t++;
         if (frame_start_o) found = 1'b1;
      end
      chk("frame_start_timeout", 32'(found), 32'd1);
      pos = 0;
   endtask

   task automatic goto(input int j);
      while (pos < j) begin
         @(negedge clk);
         pos++;
      end
   endtask

   task automatic lit(input string name, input logic [3:0] a, input logic [6:0] c);
      chk({name, "_a"}, 32'(sseg_a_o), 32'(a));
      chk({name, "_c"}, 32'(sseg_c_o), 32'(c));
   endtask

   initial begin
      int lows;
      // Reset held for three cycles.
      bcd_in = 16'h1234; brightness = 2'd3; blank_lz = 1'b0; dp_in = 4'b0000;
      repeat (3) @(negedge clk);
      lit("reset", 4'hF, 7'h7F);
      chk("reset_dp", 32'(sseg_dp_o), 32'd1);
      chk("reset_fs", 32'(frame_start_o), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("first_pulse", 32'(frame_start_o), 32'd1);

      // Plain scan of 1234 at full brightness.
      wait_frame();
      goto(1);  lit("guard0", 4'hF, 7'b0011001);
      goto(2);  lit("d0_4", 4'b1110, 7'b0011001);
      goto(5);  chk("guard1_a", 32'(sseg_a_o), 32'hF);
      goto(6);  lit("d1_3", 4'b1101, 7'b0110000);
      goto(10); lit("d2_2", 4'b1011, 7'b0100100);
      goto(14); lit("d3_1", 4'b0111, 7'b1111001);
      goto(16); chk("period16", 32'(frame_start_o), 32'd1);

      // Leading-zero blanking.
      blank_lz = 1'b1; bcd_in = 16'h0012;
      wait_frame();
      goto(2);  lit("lz_d0", 4'b1110, 7'b0100100);
      goto(6);  lit("lz_d1", 4'b1101, 7'b1111001);
      goto(10); lit("lz_d2", 4'hF, 7'h7F);
      chk("lz_d2_dp", 32'(sseg_dp_o), 32'd1);
      goto(14); lit("lz_d3", 4'hF, 7'h7F);
      bcd_in = 16'h0000;
      wait_frame();
      goto(2);  lit("zero_d0", 4'b1110, 7'b1000000);
      goto(6);  lit("zero_d1", 4'hF, 7'h7F);

      // Invalid codes and decimal points.
      bcd_in = 16'hFFFF; dp_in = 4'b0101;
      wait_frame();
      goto(2);  lit("err_d0", 4'b1110, 7'b0111111); chk("dp_d0", 32'(sseg_dp_o), 32'd0);
      goto(6);  lit("err_d1", 4'b1101, 7'b0111111); chk("dp_d1", 32'(sseg_dp_o), 32'd1);
      goto(10); chk("dp_d2", 32'(sseg_dp_o), 32'd0);
      goto(14); chk("dp_d3", 32'(sseg_dp_o), 32'd1);

      // Mid-frame input change is held off until the next frame.
      dp_in = 4'b0000; blank_lz = 1'b0; bcd_in = 16'h1234;
      wait_frame();
      goto(6);  bcd_in = 16'h5678;
      goto(10); lit("hold_d2", 4'b1011, 7'b0100100);
      goto(14); lit("hold_d3", 4'b0111, 7'b1111001);
      wait_frame();
      goto(2);  lit("new_d0", 4'b1110, 7'b0000000);
      goto(6);  lit("new_d1", 4'b1101, 7'b1111000);

      // PWM dimming.
      brightness = 2'd1;
      wait_frame();
      lows = 0;
      for (int j = 1; j <= 16; j++) begin
         goto(j);
         if (sseg_a_o != 4'hF) lows++;
         if (j == 2) chk("dim1_on", 32'(sseg_a_o), 32'b1110);
         if (j == 3) chk("dim1_off", 32'(sseg_a_o), 32'hF);
      end
      chk("dim1_count", 32'(lows), 32'd4);
      brightness = 2'd0;
      wait_frame();
      lows = 0;
      for (int j = 1; j <= 16; j++) begin
         goto(j);
         if (sseg_a_o != 4'hF) lows++;
      end
      chk("dim0_count", 32'(lows), 32'd0);

      // Reset in the middle of a slot.
      brightness = 2'd3;
      wait_frame();
      goto(7);
      rst = 1'b1;
      @(negedge clk);
      lit("midrst", 4'hF, 7'h7F);
      chk("midrst_dp", 32'(sseg_dp_o), 32'd1);
      chk("midrst_fs", 32'(frame_start_o), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("restart_fs", 32'(frame_start_o), 32'd1);
      chk("restart_guard", 32'(sseg_a_o), 32'hF);
      @(negedge clk);
      lit("restart_d0", 4'b1110, 7'b0000000);
      repeat (20) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, expected finish before %0t", $time);
      $fatal(1);
   end

endmodule
